// File: rtl/mux_pkg.sv
// Shared mode encodings for the N-to-1 arbitrating selector.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mux_pkg;

    // mode_i encoding
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible index scanning ptr, ptr+1, ..., wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with its own load condition.
//
// Ports:
//   eligible      per-channel eligible requests
//   ptr           highest-priority index for this scan
//   winner        selected index (0 when nothing is eligible)
//   any_eligible  at least one eligible bit is set
module rr_picker #(
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  winner,
    output logic              any_eligible
);

    always_comb begin
        int idx;
        idx          = 0;
        winner       = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            // ptr < NUM_CH, so a single subtraction wraps the scan index
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                winner       = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 stream selector, fixed-select or round-robin, one registered output slot.
// Latency: one cycle from input handshake to valid_o/data_o.
// Backpressure: ready_o follows ready_i combinationally; full slot with ready_i low stalls all inputs.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   data_i, valid_i       packed channel data (channel k at [k*WIDTH +: WIDTH]) and requests
//   ready_o               one-hot accept to the winning channel
//   mode_i, select_i      0 = fixed select of select_i, 1 = round-robin
//   data_o, grant_o       registered word and the channel it came from
//   valid_o, ready_i      output handshake
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]       valid_i,
    output logic [NUM_CH-1:0]       ready_o,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        select_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]        grant_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_winner;
    logic [SEL_W-1:0]  winner;
    logic              any_eligible;
    logic              select_ok;
    logic              load;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k] = data_i[k*WIDTH +: WIDTH];
        end
    end

    // Output slot is free, or its word leaves this cycle.
    assign load = !valid_o || ready_i;

    // select_i can exceed NUM_CH-1 when NUM_CH is not a power of two.
    assign select_ok = (int'(select_i) < NUM_CH);

    always_comb begin
        eligible = '0;
        if (mode_i == MODE_RR) begin
            eligible = valid_i;
        end else if (select_ok) begin
            eligible[select_i] = valid_i[select_i];
        end
    end

    rr_picker #(
        .NUM_CH(NUM_CH)
    ) u_rr_picker (
        .eligible     (eligible),
        .ptr          (ptr),
        .winner       (rr_winner),
        .any_eligible (any_eligible)
    );

    // Fixed mode overrides the scan; eligible already masks everything but select_i.
    assign winner = (mode_i == MODE_RR) ? rr_winner : select_i;

    always_comb begin
        ready_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ready_o[k] = !rst_i && load && any_eligible && (winner == SEL_W'(k));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            grant_o <= '0;
            valid_o <= 1'b0;
            ptr     <= '0;
        end else if (load) begin
            if (any_eligible) begin
                data_o  <= ch_data[winner];
                grant_o <= winner;
                valid_o <= 1'b1;
                if (mode_i == MODE_RR) begin
                    ptr <= (winner == SEL_W'(NUM_CH - 1)) ? '0 : winner + SEL_W'(1);
                end
            end else begin
                // data_o/grant_o keep the last word for debug visibility
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-to-1 datapath selector with valid/ready handshaking, round-robin or fixed-select arbitration, and a one-entry registered output stage. It generalises the CPU's combinational 4-to-1 selectors into a block that merges several producer streams into one consumer, such as write-back sources or memory request ports. Output is registered, so the select decision is removed from the downstream critical path.

## Interface
- WIDTH, 32, data width per channel
- NUM_CH, 4, number of input channels (≥2, any integer)
- SEL_W, $clog2(NUM_CH), derived localparam for select/grant width; not overridable
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; asynchronous, active-high
- data_i  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- valid_i  input  NUM_CH  per-channel request
- ready_o  output  NUM_CH  per-channel accept, combinational
- mode_i  input  1  0 = fixed select, 1 = round-robin
- select_i  input  SEL_W  channel used in fixed mode
- data_o  output  WIDTH  registered selected data
- grant_o  output  SEL_W  registered index of the channel held in data_o
- valid_o  output  1  output register holds a word
- ready_i  input  1  consumer accepts data_o this cycle

## Operation
- load = !valid_o || ready_i. This means the output slot is free or is draining this cycle.
- Eligible requests depend on mode:
  - Fixed mode: eligible = valid_i[select_i] only. If select_i ≥ NUM_CH, nothing is eligible.
  - RR mode: all valid_i bits are eligible.
- Winner selection:
  - RR mode: the first eligible index scanning ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1.
  - Fixed mode: the winner is select_i.
- ready_o[k] = load && eligible && (k == winner). At most one bit is high. All bits are 0 when there is no eligible request.
- Transfer on channel k when valid_i[k] && ready_o[k]. Its effects at the next edge:
  - data_o ← channel k data
  - grant_o ← k
  - valid_o ← 1
  - In RR mode only: ptr ← k+1, wrapping NUM_CH-1 → 0.
- load with no eligible request: valid_o ← 0. data_o and grant_o hold their last values.
- !load (valid_o && !ready_i): data_o, grant_o, valid_o and ptr all hold. This is the stall.
- Fixed mode never modifies ptr.
- A mode_i or select_i change affects only the current cycle's arbitration. It never alters a word already held.
- Channels not granted must keep valid_i and data stable. The block does not buffer them.

## Timing
- Reset (async assert, any cycle):
  - valid_o = 0, data_o = 0, grant_o = 0, ptr = 0.
  - ready_o is 0 while rst_i is high.
  - A word in flight at reset is dropped.
- Latency: a transfer in cycle t gives valid_o high with that data in cycle t+1.
- Throughput: one word per cycle while ready_i is held high and requests are present.
- Combinational paths: ready_i → ready_o, valid_i/mode_i/select_i → ready_o. There is no path from any input to data_o, valid_o or grant_o.
- Simultaneous drain and refill (valid_o && ready_i, new winner): the old word is consumed and the new word is loaded at the same edge, with no bubble.
- Wrap-around: a grant on NUM_CH-1 sets ptr to 0.
- Single requester in RR mode: it is granted every cycle regardless of ptr.

## Structure
- Shared package mux_pkg holds MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
- Sub-module rr_picker, parameterised by NUM_CH. It takes an eligible vector and ptr and returns the winner index and an any-eligible flag. It is purely combinational.
- The top level holds ptr, the output register, the load/handshake logic and the fixed-mode override.

## Test plan
- Reset mid-stream: assert rst_i while valid_o=1, data_o=0xDEADBEEF → valid_o=0, data_o=0, grant_o=0 immediately, with no clock required. After release, the first RR grant goes to channel 0.
- RR fairness: NUM_CH=4, all valid_i=1, ready_i=1, data k = 0x100+k → grant_o sequence 0,1,2,3,0,… and data_o 0x100..0x103 repeating, one per cycle.
- Stall: valid_o=1, ready_i=0 for 3 cycles → data_o, grant_o and ptr stable, ready_o=0000. ready_i=1 → the next winner loads at the same edge, with no bubble.
- Fixed mode: mode_i=0, select_i=2, valid_i=1111 → only ready_o[2]=1 and grant_o=2 every cycle. ptr remains unchanged when mode_i returns to 1.
- Fixed mode out of range: NUM_CH=3, select_i=3 → ready_o=000 and valid_o falls to 0 once drained.
- Sparse/wrap: NUM_CH=5, ptr=4, valid_i=00011 → grant order 0,1,0,1. Then valid_i=10000 → channel 4 granted and ptr wraps to 0.
